// File: rtl/char_rom_pkg.sv
// char_rom_pkg: shared widths, port ids and arbiter state encodings
// for the character ROM arbiter and its tag pipeline.
package char_rom_pkg;

   localparam int ROM_ADDR_W = 10;
   localparam int ROM_DATA_W = 16;
   localparam int LOCK_CNT_W = 8;

   localparam logic PORT_XFMR = 1'b0;
   localparam logic PORT_BCN  = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_t;

   typedef struct packed {
      logic vld;
      logic port;
   } rom_tag_t;

endpackage

// File: rtl/rom_tag_pipe.sv
// rom_tag_pipe: carries {valid, owner} alongside the ROM read latency
// so each returning word is steered to the port that issued it.
module rom_tag_pipe
   import char_rom_pkg::*;
#(
   parameter int ROM_LAT = 1
) (
   input  logic     clk,
   input  logic     rst,
   input  rom_tag_t tag_in,
   output logic     rvalid0,
   output logic     rvalid1,
   output logic     in_flight
);

   rom_tag_t [ROM_LAT-1:0] stage;

   // shift issued tags; reset drops every read still in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stage <= '0;
      end else begin
         for (int i = ROM_LAT - 1; i > 0; i--) begin
            stage[i] <= stage[i-1];
         end
         stage[0] <= tag_in;
      end
   end

   // any valid stage means a ROM word is still on its way back
   always_comb begin
      in_flight = 1'b0;
      for (int i = 0; i < ROM_LAT; i++) begin
         in_flight = in_flight | stage[i].vld;
      end
   end

   assign rvalid0 = stage[ROM_LAT-1].vld &&
                    (stage[ROM_LAT-1].port == PORT_XFMR);
   assign rvalid1 = stage[ROM_LAT-1].vld &&
                    (stage[ROM_LAT-1].port == PORT_BCN);

endmodule

// File: rtl/char_rom_arbiter.sv
// char_rom_arbiter: round-robin, lockable sharing of the packed-ASCII ROM
// between port 0 (Laplace xfmr) and port 1 (beacon). Macro ARB_STATS_EN adds stats.
module char_rom_arbiter
   import char_rom_pkg::*;
#(
   parameter int ADDR_W   = ROM_ADDR_W,
   parameter int DATA_W   = ROM_DATA_W,
   parameter int ROM_LAT  = 1,
   parameter int MAX_LOCK = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              req1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic              lock0,
   input  logic              lock1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_dout,
   output logic              busy
`ifdef ARB_STATS_EN
   ,
   input  logic              stats_clr,
   output logic [7:0]        gcnt0,
   output logic [7:0]        gcnt1,
   output logic [7:0]        stall_cnt
`endif
);

   localparam logic [LOCK_CNT_W-1:0] LOCK_LAST = LOCK_CNT_W'(MAX_LOCK - 1);

   arb_state_t            state;
   arb_state_t            state_nxt;
   logic                  rr_last;
   logic                  rr_nxt;
   logic [LOCK_CNT_W-1:0] lock_cnt;
   rom_tag_t              iss;
   logic                  in_flight;
   logic [DATA_W-1:0]     hold0;
   logic [DATA_W-1:0]     hold1;

   // grant selection and ownership transitions
   always_comb begin
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      state_nxt = state;
      rr_nxt    = rr_last;
      unique case (state)
         IDLE: begin
            if (req0 && req1) begin
               gnt0   = (rr_last == PORT_BCN);
               gnt1   = (rr_last == PORT_XFMR);
               rr_nxt = ~rr_last;
            end else begin
               gnt0 = req0;
               gnt1 = req1;
            end
            if (gnt0 && lock0) begin
               state_nxt = OWN0;
            end else if (gnt1 && lock1) begin
               state_nxt = OWN1;
            end
         end
         OWN0: begin
            gnt0 = req0;
            if (lock_cnt == LOCK_LAST) begin
               state_nxt = IDLE;
               rr_nxt    = PORT_XFMR;
            end else if (!lock0) begin
               state_nxt = IDLE;
            end
         end
         OWN1: begin
            gnt1 = req1;
            if (lock_cnt == LOCK_LAST) begin
               state_nxt = IDLE;
               rr_nxt    = PORT_BCN;
            end else if (!lock1) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (rst) begin
         gnt0 = 1'b0;
         gnt1 = 1'b0;
      end
   end

   // arbiter state, lock timer and registered ROM address issue
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         rr_last  <= PORT_BCN;
         lock_cnt <= '0;
         mem_addr <= '0;
         iss      <= '0;
      end else begin
         state    <= state_nxt;
         rr_last  <= rr_nxt;
         lock_cnt <= (state == IDLE) ? '0 : lock_cnt + 1'b1;
         if (gnt0) begin
            mem_addr <= addr0;
         end else if (gnt1) begin
            mem_addr <= addr1;
         end
         iss.vld  <= gnt0 | gnt1;
         iss.port <= gnt1 ? PORT_BCN : PORT_XFMR;
      end
   end

   rom_tag_pipe #(
      .ROM_LAT (ROM_LAT)
   ) u_tag_pipe (
      .clk       (clk),
      .rst       (rst),
      .tag_in    (iss),
      .rvalid0   (rvalid0),
      .rvalid1   (rvalid1),
      .in_flight (in_flight)
   );

   // keep the last delivered word per port for the idle rdata value
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold0 <= '0;
         hold1 <= '0;
      end else begin
         if (rvalid0) hold0 <= mem_dout;
         if (rvalid1) hold1 <= mem_dout;
      end
   end

   assign rdata0 = rvalid0 ? mem_dout : hold0;
   assign rdata1 = rvalid1 ? mem_dout : hold1;
   assign busy   = (state != IDLE) || iss.vld || in_flight;

`ifdef ARB_STATS_EN
   // saturating grant and stall counters; clear wins over increment
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gcnt0     <= '0;
         gcnt1     <= '0;
         stall_cnt <= '0;
      end else if (stats_clr) begin
         gcnt0     <= '0;
         gcnt1     <= '0;
         stall_cnt <= '0;
      end else begin
         if (gnt0 && gcnt0 != 8'hFF) gcnt0 <= gcnt0 + 8'd1;
         if (gnt1 && gcnt1 != 8'hFF) gcnt1 <= gcnt1 + 8'd1;
         if (((req0 && !gnt0) || (req1 && !gnt1)) && stall_cnt != 8'hFF)
            stall_cnt <= stall_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_char_rom_arbiter.sv
// tb_char_rom_arbiter: directed scenarios plus random traffic, checked
// against a behavioural ownership/return-queue model of the arbiter.
module tb_char_rom_arbiter;

   localparam int AW  = 10;
   localparam int DW  = 16;
   localparam int LAT = 1;
   localparam int ML  = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req0 = 1'b0, req1 = 1'b0;
   logic          lock0 = 1'b0, lock1 = 1'b0;
   logic [AW-1:0] addr0 = '0, addr1 = '0;
   logic          gnt0, gnt1, rvalid0, rvalid1, busy;
   logic [DW-1:0] rdata0, rdata1;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_dout = '0;
`ifdef ARB_STATS_EN
   logic          stats_clr = 1'b0;
   logic [7:0]    gcnt0, gcnt1, stall_cnt;
   int            m_g0 = 0, m_g1 = 0, m_st = 0;
`endif

   typedef struct {
      int            due;
      int            port;
      logic [AW-1:0] addr;
   } rd_t;

   rd_t           pend[$];
   int            owner = -1, held = 0, rr = 1, now = 0;
   int            passed = 0, checks = 0;
   logic [DW-1:0] last0 = '0, last1 = '0;
   logic [AW-1:0] exp_maddr = '0;
   logic          obs_g0 = 1'b0, obs_g1 = 1'b0;

   char_rom_arbiter #(
      .ADDR_W   (AW),
      .DATA_W   (DW),
      .ROM_LAT  (LAT),
      .MAX_LOCK (ML)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req0      (req0),
      .req1      (req1),
      .addr0     (addr0),
      .addr1     (addr1),
      .lock0     (lock0),
      .lock1     (lock1),
      .gnt0      (gnt0),
      .gnt1      (gnt1),
      .rvalid0   (rvalid0),
      .rvalid1   (rvalid1),
      .rdata0    (rdata0),
      .rdata1    (rdata1),
      .mem_addr  (mem_addr),
      .mem_dout  (mem_dout),
      .busy      (busy)
`ifdef ARB_STATS_EN
      ,
      .stats_clr (stats_clr),
      .gcnt0     (gcnt0),
      .gcnt1     (gcnt1),
      .stall_cnt (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] rom_fn(logic [AW-1:0] a);
      return DW'({6'd0, a} * 16'd3);
   endfunction

   always @(posedge clk) mem_dout <= rom_fn(mem_addr);

   initial begin
      repeat (20000) @(posedge clk);
      $display("FAIL watchdog: run did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // one clock: compare outputs with the model, then advance the model
   task automatic step();
      int   w;
      logic e0, e1;
      rd_t  r;
      #1;
      w = -1;
      if (owner < 0) begin
         if (req0 && req1) w = 1 - rr;
         else if (req0) w = 0;
         else if (req1) w = 1;
      end else if ((owner == 0 && req0) || (owner == 1 && req1)) begin
         w = owner;
      end
      obs_g0 = gnt0;
      obs_g1 = gnt1;
      check("gnt0", 32'(gnt0), 32'(w == 0));
      check("gnt1", 32'(gnt1), 32'(w == 1));
      check("mem_addr", 32'(mem_addr), 32'(exp_maddr));
      check("busy", 32'(busy), 32'(owner >= 0 || pend.size() > 0));
      e0 = 1'b0;
      e1 = 1'b0;
      if (pend.size() > 0 && pend[0].due == now) begin
         if (pend[0].port == 0) begin
            e0 = 1'b1;
            last0 = rom_fn(pend[0].addr);
         end else begin
            e1 = 1'b1;
            last1 = rom_fn(pend[0].addr);
         end
         void'(pend.pop_front());
      end
      check("rvalid0", 32'(rvalid0), 32'(e0));
      check("rvalid1", 32'(rvalid1), 32'(e1));
      check("rdata0", 32'(rdata0), 32'(last0));
      check("rdata1", 32'(rdata1), 32'(last1));
`ifdef ARB_STATS_EN
      check("gcnt0", 32'(gcnt0), 32'(m_g0));
      check("gcnt1", 32'(gcnt1), 32'(m_g1));
      check("stall_cnt", 32'(stall_cnt), 32'(m_st));
`endif
      @(posedge clk);
      if (w >= 0) begin
         r.due  = now + LAT + 1;
         r.port = w;
         r.addr = (w == 0) ? addr0 : addr1;
         pend.push_back(r);
         exp_maddr = r.addr;
      end
`ifdef ARB_STATS_EN
      if (stats_clr) begin
         m_g0 = 0;
         m_g1 = 0;
         m_st = 0;
      end else begin
         if (w == 0 && m_g0 < 255) m_g0++;
         if (w == 1 && m_g1 < 255) m_g1++;
         if (((req0 && w != 0) || (req1 && w != 1)) && m_st < 255) m_st++;
      end
`endif
      if (owner < 0) begin
         if (req0 && req1) rr = w;
         if (w >= 0 && ((w == 0) ? lock0 : lock1)) begin
            owner = w;
            held  = 0;
         end
      end else begin
         if (held == ML - 1) begin
            rr    = owner;
            owner = -1;
         end else if (!((owner == 0) ? lock0 : lock1)) begin
            owner = -1;
         end else begin
            held++;
         end
      end
      now++;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      owner = -1;
      rr    = 1;
      held  = 0;
      pend.delete();
      exp_maddr = '0;
      last0 = '0;
      last1 = '0;
`ifdef ARB_STATS_EN
      m_g0 = 0;
      m_g1 = 0;
      m_st = 0;
`endif
      @(posedge clk);
      #1;
      check("rst_gnt0", 32'(gnt0), 32'd0);
      check("rst_gnt1", 32'(gnt1), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rvalid", 32'({rvalid0, rvalid1}), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_rdata", 32'({rdata0, rdata1}), 32'd0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int       k;
      int       cnt0, cnt1;
      logic     got;
      logic [5:0] gseq;

      do_reset();

      // 1: single read from port 0
      req0 = 1'b1;
      addr0 = 10'h005;
      step();
      check("t1_gnt0", 32'(obs_g0), 32'd1);
      req0 = 1'b0;
      repeat (3) step();
      check("t1_rdata0", 32'(rdata0), 32'h000F);

`ifdef ARB_STATS_EN
      stats_clr = 1'b1;
      step();
      stats_clr = 1'b0;
`endif

      // 2: both ports, no lock: strict alternation
      req0 = 1'b1;
      req1 = 1'b1;
      gseq = '0;
      for (int i = 0; i < 6; i++) begin
         addr0 = AW'(10'h020 + i);
         addr1 = AW'(10'h040 + i);
         step();
         gseq = {gseq[4:0], obs_g1};
      end
      check("t2_alternate", 32'(gseq), 32'(6'b010101));
`ifdef ARB_STATS_EN
      #1;
      check("t6_gcnt0", 32'(gcnt0), 32'd3);
      check("t6_gcnt1", 32'(gcnt1), 32'd3);
      check("t6_stall", 32'(stall_cnt), 32'd6);
`endif
      req0 = 1'b0;
      req1 = 1'b0;
      repeat (3) step();
`ifdef ARB_STATS_EN
      stats_clr = 1'b1;
      step();
      stats_clr = 1'b0;
      #1;
      check("t6_cleared", 32'({gcnt0, gcnt1, stall_cnt}), 32'd0);
`endif

      // 3: locked burst of 4 from port 0 while port 1 waits
      req1 = 1'b1;
      addr1 = 10'h3FF;
      cnt0 = 0;
      cnt1 = 0;
      for (int i = 0; i < 4; i++) begin
         req0 = 1'b1;
         lock0 = 1'b1;
         addr0 = AW'(10'h010 + i);
         step();
         cnt0 += int'(obs_g0);
         cnt1 += int'(obs_g1);
      end
      check("t3_burst_gnt0", 32'(cnt0), 32'd4);
      check("t3_burst_gnt1", 32'(cnt1), 32'd0);
      req0 = 1'b0;
      lock0 = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 2; i++) begin
         if (!got) begin
            step();
            got = obs_g1;
         end
      end
      check("t3_gnt1_after", 32'(got), 32'd1);
      req1 = 1'b0;
      repeat (3) step();

      // 4: stuck lock is force-released
      req0 = 1'b1;
      lock0 = 1'b1;
      addr0 = 10'h100;
      step();
      check("t4_first_gnt0", 32'(obs_g0), 32'd1);
      req1 = 1'b1;
      addr1 = 10'h200;
      k = 0;
      got = 1'b0;
      while (!got && k < 20) begin
         k++;
         step();
         got = obs_g1;
      end
      check("t4_gnt1_by9", 32'(got && k <= 9), 32'd1);
      req0 = 1'b0;
      lock0 = 1'b0;
      req1 = 1'b0;
      repeat (3) step();
      check("t4_idle", 32'(busy), 32'd0);

      // 5: reset with a read in flight
      req0 = 1'b1;
      addr0 = 10'h07A;
      step();
      req1 = 1'b1;
      do_reset();
      step();
      check("t5_tie_port0", 32'(obs_g0), 32'd1);
      req0 = 1'b0;
      req1 = 1'b0;
      repeat (2) step();

      // random traffic with requests held until granted
      for (int n = 0; n < 400; n++) begin
         if (!req0 || obs_g0) begin
            req0 = 1'($urandom_range(0, 1));
            addr0 = AW'($urandom);
         end
         if (!req1 || obs_g1) begin
            req1 = 1'($urandom_range(0, 1));
            addr1 = AW'($urandom);
         end
         lock0 = ($urandom_range(0, 3) == 0);
         lock1 = ($urandom_range(0, 3) == 0);
         if (n == 200) do_reset();
         step();
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
